// File: rtl/bin_pkg.sv
// Shared bin geometry package: widths and the decoder/search state encoding.
package bin_pkg;

    // Bin index / bin count width; also the shift-add iteration count.
    localparam int IDX_W   = 6;
    // Bin width and origin width.
    localparam int WIDTH_W = 16;
    // Signed reconstructed value width.
    localparam int OUT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MULT   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage : bin_pkg

// File: rtl/bin_edge_decoder_mult.sv
// Sequential shift-add multiplier: unsigned A_W x B_W, one multiplier bit per
// cycle, LSB first, A_W cycles after the start edge.
module shift_add_mult #(
    parameter int A_W = 6,
    parameter int B_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [A_W-1:0]       a_i,
    input  logic [B_W-1:0]       b_i,
    output logic                 last_o,
    output logic [A_W+B_W-1:0]   product_o
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;

    logic             running_q, running_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [P_W-1:0]   b_q, b_d;
    logic [P_W-1:0]   acc_q, acc_d;

    // High on the edge that performs the final iteration; product_o is
    // complete from the following cycle onward.
    assign last_o    = running_q && (cnt_q == CNT_W'(A_W - 1));
    assign product_o = acc_q;

    // Next-state: load on start, otherwise consume one multiplier bit per cycle.
    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        if (start_i) begin
            running_d = 1'b1;
            cnt_d     = '0;
            a_d       = a_i;
            b_d       = {{A_W{1'b0}}, b_i};
            acc_d     = '0;
        end else if (running_q) begin
            if (a_q[0]) begin
                acc_d = acc_q + b_q;
            end
            a_d   = a_q >> 1;
            b_d   = b_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_o) begin
                running_d = 1'b0;
            end
        end
    end

    // State registers; reset aborts any multiply and clears the accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
        end
    end

endmodule : shift_add_mult

// File: rtl/bin_edge_decoder.sv
// Bin index -> signed value range decoder (lower edge, centre, upper edge).
// index*bin_width comes from a sequential shift-add multiplier, so no DSPs.
module bin_edge_decoder
    import bin_pkg::*;
#(
    parameter int IDX_W   = bin_pkg::IDX_W,
    parameter int WIDTH_W = bin_pkg::WIDTH_W,
    parameter int OUT_W   = bin_pkg::OUT_W
) (
    input  logic                      clk100,
    input  logic                      rst,
    input  logic                      data_in,
    input  logic [IDX_W-1:0]          bin_idx,
    input  logic [IDX_W-1:0]          num_bins,
    input  logic [WIDTH_W-1:0]        bin_width,
    input  logic [WIDTH_W-1:0]        origin,
    output logic                      busy,
    output logic                      done,
    output logic signed [OUT_W-1:0]   lower_edge,
    output logic signed [OUT_W-1:0]   center,
    output logic signed [OUT_W-1:0]   upper_edge,
    output logic                      out_of_range
);

    localparam int P_W = IDX_W + WIDTH_W;

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     oor_q, oor_d;
    logic signed [OUT_W-1:0]  lower_q, lower_d;
    logic signed [OUT_W-1:0]  center_q, center_d;
    logic signed [OUT_W-1:0]  upper_q, upper_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         nb_q, nb_d;
    logic [WIDTH_W-1:0]       width_q, width_d;
    logic [WIDTH_W-1:0]       origin_q, origin_d;

    logic                     mult_start;
    logic                     mult_last;
    logic [P_W-1:0]           product;

    logic signed [OUT_W-1:0]  origin_ext;
    logic signed [OUT_W-1:0]  prod_ext;
    logic signed [OUT_W-1:0]  width_ext;
    logic signed [OUT_W-1:0]  half_ext;
    logic signed [OUT_W-1:0]  lower_w;

    // origin is signed (sign-extend); product and bin_width are unsigned (zero-extend).
    assign origin_ext = {{(OUT_W-WIDTH_W){origin_q[WIDTH_W-1]}}, origin_q};
    assign prod_ext   = {{(OUT_W-P_W){1'b0}}, product};
    assign width_ext  = {{(OUT_W-WIDTH_W){1'b0}}, width_q};
    assign half_ext   = {{(OUT_W-WIDTH_W+1){1'b0}}, width_q[WIDTH_W-1:1]};
    assign lower_w    = origin_ext + prod_ext;

    shift_add_mult #(
        .A_W (IDX_W),
        .B_W (WIDTH_W)
    ) u_mult (
        .clk_i     (clk100),
        .rst_i     (rst),
        .start_i   (mult_start),
        .a_i       (bin_idx),
        .b_i       (bin_width),
        .last_o    (mult_last),
        .product_o (product)
    );

    // Control FSM: accept a start in IDLE, wait out the multiply, then publish.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        oor_d      = oor_q;
        lower_d    = lower_q;
        center_d   = center_q;
        upper_d    = upper_q;
        idx_d      = idx_q;
        nb_d       = nb_q;
        width_d    = width_q;
        origin_d   = origin_q;
        mult_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (data_in) begin
                    mult_start = 1'b1;
                    idx_d      = bin_idx;
                    nb_d       = num_bins;
                    width_d    = bin_width;
                    origin_d   = origin;
                    busy_d     = 1'b1;
                    state_d    = ST_MULT;
                end
            end
            ST_MULT: begin
                if (mult_last) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                lower_d  = lower_w;
                center_d = lower_w + half_ext;
                upper_d  = lower_w + width_ext;
                oor_d    = (idx_q >= nb_q);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Registers; reset aborts any decode and zeroes every output.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            oor_q    <= 1'b0;
            lower_q  <= '0;
            center_q <= '0;
            upper_q  <= '0;
            idx_q    <= '0;
            nb_q     <= '0;
            width_q  <= '0;
            origin_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            oor_q    <= oor_d;
            lower_q  <= lower_d;
            center_q <= center_d;
            upper_q  <= upper_d;
            idx_q    <= idx_d;
            nb_q     <= nb_d;
            width_q  <= width_d;
            origin_q <= origin_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign out_of_range = oor_q;
    assign lower_edge   = lower_q;
    assign center       = center_q;
    assign upper_edge   = upper_q;

endmodule : bin_edge_decoder

// File: tb/tb_bin_edge_decoder.sv
// Directed bench for bin_edge_decoder with hand-computed expected values.
`timescale 1ns/1ps
module tb_bin_edge_decoder;

    localparam int IDX_W   = 6;
    localparam int WIDTH_W = 16;
    localparam int OUT_W   = 32;

    logic                     clk100;
    logic                     rst;
    logic                     data_in;
    logic [IDX_W-1:0]         bin_idx;
    logic [IDX_W-1:0]         num_bins;
    logic [WIDTH_W-1:0]       bin_width;
    logic [WIDTH_W-1:0]       origin;
    logic                     busy;
    logic                     done;
    logic signed [OUT_W-1:0]  lower_edge;
    logic signed [OUT_W-1:0]  center;
    logic signed [OUT_W-1:0]  upper_edge;
    logic                     out_of_range;

    int n_checks = 0;
    int n_pass   = 0;

    bin_edge_decoder #(
        .IDX_W   (IDX_W),
        .WIDTH_W (WIDTH_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clk100       (clk100),
        .rst          (rst),
        .data_in      (data_in),
        .bin_idx      (bin_idx),
        .num_bins     (num_bins),
        .bin_width    (bin_width),
        .origin       (origin),
        .busy         (busy),
        .done         (done),
        .lower_edge   (lower_edge),
        .center       (center),
        .upper_edge   (upper_edge),
        .out_of_range (out_of_range)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Present operands and hold data_in across one rising edge (E0).
    task automatic start_op(input int idx, input int nb, input int w, input int org);
        @(negedge clk100);
        bin_idx   = IDX_W'(idx);
        num_bins  = IDX_W'(nb);
        bin_width = WIDTH_W'(w);
        origin    = WIDTH_W'(org);
        data_in   = 1'b1;
        @(posedge clk100);
        #1;
        data_in = 1'b0;
    endtask

    // Called #1 after some edge; returns edges until done is seen (-1 if never)
    // and how many sampled cycles had busy high before done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk100);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic check_vals(input string tag, input longint lo, input longint ce,
                              input longint up, input longint oor);
        check({tag, ".lower"},  longint'(lower_edge), lo);
        check({tag, ".center"}, longint'(center), ce);
        check({tag, ".upper"},  longint'(upper_edge), up);
        check({tag, ".oor"},    longint'(out_of_range), oor);
    endtask

    task automatic run_case(input string tag, input int idx, input int nb, input int w,
                            input int org, input longint lo, input longint ce,
                            input longint up, input longint oor);
        int lat, bcnt;
        start_op(idx, nb, w, org);
        wait_done(lat, bcnt);
        check({tag, ".latency"}, lat, 7);
        check({tag, ".busy_cycles"}, bcnt, 7);
        check({tag, ".busy_at_done"}, longint'(busy), 0);
        check_vals(tag, lo, ce, up, oor);
        @(posedge clk100);
        #1;
        check({tag, ".done_pulse"}, longint'(done), 0);
    endtask

    initial begin
        int lat, bcnt, spurious;
        rst = 1'b1; data_in = 1'b0;
        bin_idx = '0; num_bins = '0; bin_width = '0; origin = '0;
        repeat (3) @(posedge clk100);
        #1;
        check("rst.busy", longint'(busy), 0);
        check("rst.done", longint'(done), 0);
        check_vals("rst", 0, 0, 0, 0);
        @(negedge clk100);
        rst = 1'b0;

        run_case("basic",  3, 20, 1, 0, 3, 3, 4, 0);
        run_case("negorg", 5, 20, 10, -100, -50, -45, -40, 0);
        run_case("max",    63, 63, 65535, -32768, 4095937, 4128704, 4161472, 1);
        run_case("idx_eq_nb", 20, 20, 4, 10, 90, 92, 94, 1);
        run_case("nb_zero",   0, 0, 6, -7, -7, -4, -1, 1);
        run_case("width0",    5, 20, 0, 123, 123, 123, 123, 0);

        // Strobe during MULT is ignored; outputs hold the previous result meanwhile.
        start_op(2, 20, 10, -100);
        repeat (2) @(posedge clk100);
        @(negedge clk100);
        bin_idx = 6'd9; data_in = 1'b1;
        @(posedge clk100);
        #1;
        data_in = 1'b0;
        check("hold.lower", longint'(lower_edge), 123);
        wait_done(lat, bcnt);
        check("ignore.latency", lat, 4);
        check_vals("ignore", -80, -75, -70, 0);
        // Restart in the done cycle.
        bin_idx = 6'd4; data_in = 1'b1;
        @(posedge clk100);
        #1;
        data_in = 1'b0;
        wait_done(lat, bcnt);
        check("b2b.latency", lat, 7);
        check_vals("b2b", -60, -55, -50, 0);

        // Reset during MULT aborts the decode.
        start_op(5, 20, 10, -100);
        repeat (4) @(posedge clk100);
        #1;
        rst = 1'b1;
        #1;
        check("abort.busy", longint'(busy), 0);
        check_vals("abort", 0, 0, 0, 0);
        spurious = 0;
        repeat (2) begin
            @(posedge clk100);
            #1;
            if (done) spurious++;
        end
        @(negedge clk100);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk100);
            #1;
            if (done) spurious++;
        end
        check("abort.no_done", spurious, 0);
        run_case("after_rst", 7, 20, 3, 5, 26, 27, 29, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bin_edge_decoder
